// File: rtl/alu64_ripple_reg.sv
`default_nettype none
// ============================================================================
// Module   : alu64_ripple_reg
// Brief    : Ripple-carry ALU built from 1-bit slices (AND/OR/ADD/SUB/SLT/NOR)
//            with Zero/Overflow flags; all outputs registered once.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Ordinary 1-bit slice: operand inversion, full adder and 4:1 result mux.
// ----------------------------------------------------------------------------
module alu64_ripple_reg_slice (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       ainvert_i,
    input  logic       bnegate_i,
    input  logic       cin_i,
    input  logic       less_i,
    input  logic [1:0] op_i,
    output logic       res_o,
    output logic       cout_o
);

    logic w_a_eff;
    logic w_b_eff;
    logic w_sum;

    assign w_a_eff = a_i ^ ainvert_i;
    assign w_b_eff = b_i ^ bnegate_i;
    assign w_sum   = w_a_eff ^ w_b_eff ^ cin_i;
    assign cout_o  = (w_a_eff & w_b_eff) | (w_a_eff & cin_i) | (w_b_eff & cin_i);

    always_comb begin
        res_o = 1'b0;
        case (op_i)
            2'b00:   res_o = w_a_eff & w_b_eff;
            2'b01:   res_o = w_a_eff | w_b_eff;
            2'b10:   res_o = w_sum;
            default: res_o = less_i;
        endcase
    end

endmodule

// ----------------------------------------------------------------------------
// MSB slice: same datapath, plus signed Overflow and the SLT Set bit.
// ----------------------------------------------------------------------------
module alu64_ripple_reg_msb_slice (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       ainvert_i,
    input  logic       bnegate_i,
    input  logic       cin_i,
    input  logic       less_i,
    input  logic [1:0] op_i,
    output logic       res_o,
    output logic       set_o,
    output logic       ovf_o
);

    logic w_a_eff;
    logic w_b_eff;
    logic w_sum;
    logic w_cout;

    assign w_a_eff = a_i ^ ainvert_i;
    assign w_b_eff = b_i ^ bnegate_i;
    assign w_sum   = w_a_eff ^ w_b_eff ^ cin_i;
    assign w_cout  = (w_a_eff & w_b_eff) | (w_a_eff & cin_i) | (w_b_eff & cin_i);

    // Correcting the sign bit by overflow keeps SLT right when a-b overflows.
    assign ovf_o = cin_i ^ w_cout;
    assign set_o = w_sum ^ ovf_o;

    always_comb begin
        res_o = 1'b0;
        case (op_i)
            2'b00:   res_o = w_a_eff & w_b_eff;
            2'b01:   res_o = w_a_eff | w_b_eff;
            2'b10:   res_o = w_sum;
            default: res_o = less_i;
        endcase
    end

endmodule

// ----------------------------------------------------------------------------
// Top level: slice chain, operation decode, flags and output registers.
// ----------------------------------------------------------------------------
module alu64_ripple_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_NOR = 4'b1100;

    logic             w_ainvert;
    logic             w_bnegate;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_slice_res;
    logic             w_set;
    logic             w_ovf_raw;
    logic             w_msb_cin;
    logic             w_op_legal;
    logic             w_op_arith;

    logic [WIDTH-1:0] result_d;
    logic             overflow_d;
    logic             zero_d;

    logic [WIDTH-1:0] result_q;
    logic             overflow_q;
    logic             zero_q;
    logic             out_valid_q;

    assign w_ainvert = operation[3];
    assign w_bnegate = operation[2];
    assign w_op      = operation[1:0];

    // Each slice keeps its own carry net so the chain is not one looped vector.
    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_slice
        logic w_cin;
        logic w_cout;

        if (i == 0) begin : g_lsb
            assign w_cin = w_bnegate;
        end else begin : g_mid
            assign w_cin = g_slice[i-1].w_cout;
        end

        alu64_ripple_reg_slice u_slice (
            .a_i       (a[i]),
            .b_i       (b[i]),
            .ainvert_i (w_ainvert),
            .bnegate_i (w_bnegate),
            .cin_i     (w_cin),
            .less_i    ((i == 0) ? w_set : 1'b0),
            .op_i      (w_op),
            .res_o     (w_slice_res[i]),
            .cout_o    (w_cout)
        );
    end

    assign w_msb_cin = g_slice[WIDTH-2].w_cout;

    alu64_ripple_reg_msb_slice u_msb_slice (
        .a_i       (a[WIDTH-1]),
        .b_i       (b[WIDTH-1]),
        .ainvert_i (w_ainvert),
        .bnegate_i (w_bnegate),
        .cin_i     (w_msb_cin),
        .less_i    (1'b0),
        .op_i      (w_op),
        .res_o     (w_slice_res[WIDTH-1]),
        .set_o     (w_set),
        .ovf_o     (w_ovf_raw)
    );

    always_comb begin
        w_op_legal = 1'b0;
        w_op_arith = 1'b0;
        case (operation)
            c_OP_AND, c_OP_OR, c_OP_SLT, c_OP_NOR: begin
                w_op_legal = 1'b1;
            end
            c_OP_ADD, c_OP_SUB: begin
                w_op_legal = 1'b1;
                w_op_arith = 1'b1;
            end
            default: begin
                w_op_legal = 1'b0;
                w_op_arith = 1'b0;
            end
        endcase
    end

    assign result_d   = w_op_legal ? w_slice_res : '0;
    assign overflow_d = w_op_arith & w_ovf_raw;
    assign zero_d     = ~|result_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                result_q   <= result_d;
                overflow_q <= overflow_d;
                zero_q     <= zero_d;
            end
        end
    end

    assign result    = result_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_alu64_ripple_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu64_ripple_reg
// Brief    : Scoreboard bench for alu64_ripple_reg with a signed-arithmetic
//            reference model, directed corner cases and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu64_ripple_reg;

    localparam int W = 64;

    localparam logic [3:0] c_AND = 4'b0000;
    localparam logic [3:0] c_OR  = 4'b0001;
    localparam logic [3:0] c_ADD = 4'b0010;
    localparam logic [3:0] c_SUB = 4'b0110;
    localparam logic [3:0] c_SLT = 4'b0111;
    localparam logic [3:0] c_NOR = 4'b1100;

    localparam logic [W-1:0] c_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] c_MAX = {1'b0, {(W-1){1'b1}}};

    typedef struct {
        logic [W-1:0] r;
        logic         ovf;
        logic         z;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   operation;
    logic [W-1:0] result;
    logic         overflow;
    logic         zero;
    logic         out_valid;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t sb[$];
    exp_t last;

    alu64_ripple_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .operation (operation),
        .result    (result),
        .overflow  (overflow),
        .zero      (zero),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain two's-complement arithmetic on whole words.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        e.r   = '0;
        e.ovf = 1'b0;
        e.cyc = 0;
        case (op)
            c_AND: e.r = av & bv;
            c_OR:  e.r = av | bv;
            c_NOR: e.r = ~(av | bv);
            c_SLT: e.r = ($signed(av) < $signed(bv)) ? W'(1) : W'(0);
            c_ADD: begin
                e.r   = av + bv;
                e.ovf = (av[W-1] == bv[W-1]) && (e.r[W-1] != av[W-1]);
            end
            c_SUB: begin
                e.r   = av - bv;
                e.ovf = (av[W-1] != bv[W-1]) && (e.r[W-1] != av[W-1]);
            end
            default: e.r = '0;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        operation = op;
        a         = av;
        b         = bv;
        e         = model(op, av, bv);
        e.cyc     = cyc;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            operation = 4'($urandom_range(0, 15));
            a         = {$urandom, $urandom};
            b         = {$urandom, $urandom};
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return c_MIN;
            3:       return c_MAX;
            4:       return W'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic clear_model();
        sb.delete();
        last.r   = '0;
        last.ovf = 1'b0;
        last.z   = 1'b0;
        last.cyc = 0;
    endtask

    // Monitor: pops on every presented result, otherwise checks that outputs hold.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", W'(out_valid), W'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result",   result,        e.r);
                    check("overflow", W'(overflow),  W'(e.ovf));
                    check("zero",     W'(zero),      W'(e.z));
                    check("latency",  W'(cyc),       W'(e.cyc + 1));
                    last = e;
                end
            end else begin
                check("hold_result",   result,       last.r);
                check("hold_overflow", W'(overflow), W'(last.ovf));
                check("hold_zero",     W'(zero),     W'(last.z));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        operation = c_ADD;
        a         = {$urandom, $urandom};
        b         = {$urandom, $urandom};
        repeat (2) @(posedge clk);
        #1;
        check("reset_result",    result,        '0);
        check("reset_overflow",  W'(overflow),  W'(0));
        check("reset_zero",      W'(zero),      W'(0));
        check("reset_out_valid", W'(out_valid), W'(0));
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases, back to back.
        issue(c_ADD, W'(123), W'(4));
        issue(c_ADD, -W'(5), W'(12));
        issue(c_SUB, W'(254), W'(254));
        issue(c_SUB, W'(20), W'(111));
        issue(c_AND, W'(10), W'(12));
        issue(c_OR,  W'(10), W'(12));
        issue(c_NOR, W'(0), W'(0));
        issue(c_SLT, W'(123), W'(10242));
        issue(c_SLT, W'(10242), W'(123));
        issue(c_SLT, '1, W'(1));
        issue(c_SLT, c_MIN, W'(1));
        issue(c_SLT, c_MAX, c_MIN);
        issue(c_ADD, c_MAX, W'(1));
        issue(c_SUB, c_MIN, W'(1));
        issue(4'b0011, W'(77), W'(5));
        idle(2);
        issue(c_SUB, W'(9), W'(3));
        idle(3);

        // Mid-stream asynchronous reset: outputs must clear before the next edge.
        issue(c_ADD, W'(123), W'(4));
        issue(c_OR,  W'(1), W'(2));
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        clear_model();
        #1;
        check("async_rst_result",    result,        '0);
        check("async_rst_out_valid", W'(out_valid), W'(0));
        check("async_rst_overflow",  W'(overflow),  W'(0));
        check("async_rst_zero",      W'(zero),      W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with occasional gaps and illegal opcodes.
        for (int n = 0; n < 300; n++) begin
            logic [3:0] op;
            case ($urandom_range(0, 6))
                0: op = c_AND;
                1: op = c_OR;
                2: op = c_ADD;
                3: op = c_SUB;
                4: op = c_SLT;
                5: op = c_NOR;
                default: op = 4'($urandom_range(0, 15));
            endcase
            issue(op, rand_operand(), rand_operand());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(3);
        check("scoreboard_drained", W'(sb.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
